arrow_scheduler: RTL

ARROW_SCHEDULER -- requirements
Module: arrow_scheduler

---
 rtl/arrow_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/arrow_scheduler.sv
// arrow_scheduler: frame-paced spawner and resolver for four arrow slots, tracking player HP and score.
// Optional feature: define ARROW_SCHED_INVERSE_EN to drive inversed_out on direction-00 spawns.
module arrow_scheduler #(
  parameter int SPAWN_FRAMES    = 30,
  parameter int LIFETIME_FRAMES = 240,
  parameter int HP_INIT         = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start,
  input  logic [3:0]  is_hit_in,
  input  logic [3:0]  hit_player_in,
  output logic [3:0]  slot_valid_out,
  output logic [7:0]  direction_out,
  output logic [11:0] speed_out,
  output logic [3:0]  inversed_out,
  output logic [2:0]  hp_out,
  output logic [7:0]  score_out,
  output logic        game_over,
  output logic        running
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [15:0]     r_lfsr;
  logic [7:0]      r_frameCnt;
  logic [3:0]      r_valid;
  logic [3:0]      r_hitPrev;
  logic [3:0][1:0] r_dir;
  logic [3:0][2:0] r_spd;
  logic [3:0][9:0] r_life;
  logic [2:0]      r_hp;
  logic [7:0]      r_score;

  logic            w_frameTick;
  logic            w_spawnAttempt;
  logic            w_spawnFound;
  logic            w_gameEnd;
  logic [3:0]      w_rise;
  logic [3:0]      w_resolve;
  logic [3:0]      w_hitMask;
  logic [3:0]      w_blockMask;
  logic [3:0]      w_expire;
  logic [3:0]      w_spawnSel;
  logic [3:0]      w_spawnLoad;
  logic [3:0]      w_free;
  logic [2:0]      w_hitCnt;
  logic [2:0]      w_blockCnt;
  logic [2:0]      w_hpNext;
  logic [8:0]      w_scoreSum;
  logic [7:0]      w_scoreNext;
  logic [15:0]     w_lfsrNext;

  function automatic logic [2:0] popCount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  assign w_frameTick    = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_lfsrNext     = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_spawnAttempt = (r_state == RUN) && w_frameTick &&
                          (r_frameCnt == 8'(SPAWN_FRAMES - 1));

  // Resolution, expiry and spawn selection all look at the registered valids,
  // so a slot freed this cycle cannot be re-spawned until the next one.
  always_comb begin
    w_rise       = is_hit_in & ~r_hitPrev;
    w_resolve    = (r_state == RUN) ? (w_rise & r_valid) : 4'b0000;
    w_hitMask    = w_resolve & hit_player_in;
    w_blockMask  = w_resolve & ~hit_player_in;
    w_hitCnt     = popCount4(w_hitMask);
    w_blockCnt   = popCount4(w_blockMask);
    w_hpNext     = (r_hp > w_hitCnt) ? (r_hp - w_hitCnt) : 3'd0;
    w_scoreSum   = {1'b0, r_score} + {6'd0, w_blockCnt};
    w_scoreNext  = w_scoreSum[8] ? 8'hFF : w_scoreSum[7:0];
    w_gameEnd    = (r_state == RUN) && (w_hpNext == 3'd0);
    w_expire     = 4'b0000;
    w_spawnSel   = 4'b0000;
    w_spawnFound = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_expire[i] = (r_state == RUN) && w_frameTick && r_valid[i] &&
                    (r_life[i] == 10'(LIFETIME_FRAMES - 1));
      if (!r_valid[i] && !w_spawnFound) begin
        w_spawnSel[i] = 1'b1;
        w_spawnFound  = 1'b1;
      end
    end
    w_spawnLoad = (w_spawnAttempt && !w_gameEnd) ? w_spawnSel : 4'b0000;
    w_free      = w_resolve | w_expire;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE, OVER: if (start) w_stateNext = RUN;
      RUN:        if (w_gameEnd) w_stateNext = OVER;
      default:    w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_stateNext;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lfsr     <= 16'hACE1;
      r_frameCnt <= 8'd0;
      r_valid    <= 4'b0000;
      r_hitPrev  <= 4'b0000;
      r_dir      <= '0;
      r_spd      <= '0;
      r_life     <= '0;
      r_hp       <= 3'(HP_INIT);
      r_score    <= 8'd0;
    end else begin
      r_hitPrev <= is_hit_in;
      if (r_state != RUN) begin
        if (start) begin
          r_hp       <= 3'(HP_INIT);
          r_score    <= 8'd0;
          r_frameCnt <= 8'd0;
          r_valid    <= 4'b0000;
        end
      end else begin
        if (w_frameTick) begin
          r_lfsr     <= w_lfsrNext;
          r_frameCnt <= w_spawnAttempt ? 8'd0 : (r_frameCnt + 8'd1);
        end
        r_hp    <= w_hpNext;
        r_score <= w_scoreNext;
        for (int i = 0; i < 4; i++) begin
          if (w_gameEnd || w_free[i]) begin
            r_valid[i] <= 1'b0;
          end else if (w_spawnLoad[i]) begin
            r_valid[i] <= 1'b1;
            r_dir[i]   <= r_lfsr[1:0];
            r_spd[i]   <= 3'd1 + {1'b0, r_lfsr[3:2]};
            r_life[i]  <= 10'd0;
          end else if (w_frameTick && r_valid[i]) begin
            r_life[i] <= r_life[i] + 10'd1;
          end
        end
      end
    end
  end

`ifdef ARROW_SCHED_INVERSE_EN
  logic [3:0] r_inv;

  // Only upward/direction-00 arrows may be inverted; the flag is latched with the spawn.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inv <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_spawnLoad[i]) r_inv[i] <= (r_lfsr[1:0] == 2'b00) ? r_lfsr[4] : 1'b0;
      end
    end
  end

  assign inversed_out = r_inv;
`else
  assign inversed_out = 4'b0000;
`endif

  assign slot_valid_out = r_valid;
  assign direction_out  = r_dir;
  assign speed_out      = r_spd;
  assign hp_out         = r_hp;
  assign score_out      = r_score;
  assign running        = (r_state == RUN);
  assign game_over      = (r_state == OVER);

endmodule
